// File: rtl/ir_packet_transmitter.sv
// Serialises one carrier-modulated IR control packet per SEND_PACKET strobe:
// start, car-select and four direction bursts, each followed by a carrier-off gap.
module ir_packet_transmitter #(
  parameter int CARRIER_PERIOD   = 1389,
  parameter int START_BURST      = 88,
  parameter int CAR_SELECT_BURST = 22,
  parameter int GAP_SIZE         = 40,
  parameter int ASSERT_BURST     = 44,
  parameter int DEASSERT_BURST   = 22
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SEND_PACKET,
  input  logic [3:0] COMMAND,
  output logic       IR_LED,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_GAP1, S_CAR_SEL, S_GAP2, S_RIGHT, S_GAP3,
    S_LEFT, S_GAP4, S_BACKWARD, S_GAP5, S_FORWARD, S_GAP6
  } state_t;

  localparam logic [15:0] PHASE_LAST = 16'(CARRIER_PERIOD - 1);
  localparam logic [15:0] PHASE_HALF = 16'(CARRIER_PERIOD / 2);
  localparam logic [7:0]  SZ_START   = 8'(START_BURST);
  localparam logic [7:0]  SZ_CAR     = 8'(CAR_SELECT_BURST);
  localparam logic [7:0]  SZ_GAP     = 8'(GAP_SIZE);
  localparam logic [7:0]  SZ_ASSERT  = 8'(ASSERT_BURST);
  localparam logic [7:0]  SZ_DEASSERT = 8'(DEASSERT_BURST);

  state_t      state, state_next;
  logic [15:0] phase;
  logic [7:0]  period;
  logic [3:0]  cmd_lat;
  logic [7:0]  size;
  logic        state_done;
  logic        burst;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    size  = SZ_GAP;
    burst = 1'b0;
    case (state)
      S_START:    begin size = SZ_START; burst = 1'b1; end
      S_CAR_SEL:  begin size = SZ_CAR;   burst = 1'b1; end
      S_RIGHT:    begin size = cmd_lat[0] ? SZ_ASSERT : SZ_DEASSERT; burst = 1'b1; end
      S_LEFT:     begin size = cmd_lat[1] ? SZ_ASSERT : SZ_DEASSERT; burst = 1'b1; end
      S_BACKWARD: begin size = cmd_lat[2] ? SZ_ASSERT : SZ_DEASSERT; burst = 1'b1; end
      S_FORWARD:  begin size = cmd_lat[3] ? SZ_ASSERT : SZ_DEASSERT; burst = 1'b1; end
      default:    begin size = SZ_GAP;   burst = 1'b0; end
    endcase
  end

  assign state_done = (phase == PHASE_LAST) && (period == 8'(size - 8'd1));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (SEND_PACKET) state_next = S_START;
      S_START:    if (state_done)  state_next = S_GAP1;
      S_GAP1:     if (state_done)  state_next = S_CAR_SEL;
      S_CAR_SEL:  if (state_done)  state_next = S_GAP2;
      S_GAP2:     if (state_done)  state_next = S_RIGHT;
      S_RIGHT:    if (state_done)  state_next = S_GAP3;
      S_GAP3:     if (state_done)  state_next = S_LEFT;
      S_LEFT:     if (state_done)  state_next = S_GAP4;
      S_GAP4:     if (state_done)  state_next = S_BACKWARD;
      S_BACKWARD: if (state_done)  state_next = S_GAP5;
      S_GAP5:     if (state_done)  state_next = S_FORWARD;
      S_FORWARD:  if (state_done)  state_next = S_GAP6;
      S_GAP6:     if (state_done)  state_next = S_IDLE;
      default:                     state_next = S_IDLE;
    endcase
  end

  // Counters restart on every state change so each burst begins phase-aligned.
  always_ff @(posedge CLK) begin
    if (RST || (state == S_IDLE) || (state_next != state)) begin
      phase  <= '0;
      period <= '0;
    end else if (phase == PHASE_LAST) begin
      phase  <= '0;
      period <= period + 8'd1;
    end else begin
      phase  <= phase + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)                               cmd_lat <= '0;
    else if ((state == S_IDLE) && SEND_PACKET) cmd_lat <= COMMAND;
  end

  assign IR_LED = burst && (phase < PHASE_HALF);
  assign BUSY   = (state != S_IDLE);

endmodule

// File: tb/tb_ir_packet_transmitter.sv
// Bench for ir_packet_transmitter: a waveform-queue model predicts IR_LED/BUSY every
// cycle, and directed scenarios pin packet lengths and burst counts to literals.
module tb_ir_packet_transmitter;

  localparam int CP = 4;
  localparam int SB = 3;
  localparam int CS = 2;
  localparam int GS = 2;
  localparam int AB = 3;
  localparam int DB = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [3:0] cmd = 4'd0;
  logic       ir_led;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ir_packet_transmitter #(
    .CARRIER_PERIOD(CP), .START_BURST(SB), .CAR_SELECT_BURST(CS),
    .GAP_SIZE(GS), .ASSERT_BURST(AB), .DEASSERT_BURST(DB)
  ) dut (
    .CLK(clk), .RST(rst), .SEND_PACKET(send), .COMMAND(cmd),
    .IR_LED(ir_led), .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: one {ir, busy} entry per cycle of the packet in flight; front = current cycle.
  logic [1:0] exp_q[$];

  function automatic void build_packet(input logic [3:0] c);
    int  sz[12];
    bit  br[12];
    sz = '{SB, GS, CS, GS, c[0] ? AB : DB, GS, c[1] ? AB : DB, GS,
           c[2] ? AB : DB, GS, c[3] ? AB : DB, GS};
    br = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    for (int s = 0; s < 12; s++)
      for (int p = 0; p < sz[s] * CP; p++)
        exp_q.push_back({br[s] && ((p % CP) < (CP / 2)), 1'b1});
  endfunction

  always @(posedge clk) begin
    if (rst)                    exp_q.delete();
    else if (exp_q.size() > 0)  void'(exp_q.pop_front());
    else if (send)              build_packet(cmd);
  end

  // Per-cycle comparison plus per-packet busy length and IR rising-edge count.
  int   busy_run = 0;
  int   rise_run = 0;
  int   last_len = 0;
  int   last_rises = 0;
  int   pkt_done = 0;
  logic prev_ir = 1'b0;

  always @(negedge clk) begin
    logic [1:0] e;
    e = (exp_q.size() > 0) ? exp_q[0] : 2'b00;
    check("ir_led", int'(ir_led), int'(e[1]));
    check("busy", int'(busy), int'(e[0]));
    if (busy) begin
      busy_run++;
      if (ir_led && !prev_ir) rise_run++;
    end else if (busy_run > 0) begin
      last_len   = busy_run;
      last_rises = rise_run;
      busy_run   = 0;
      rise_run   = 0;
      pkt_done++;
    end
    prev_ir = ir_led;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [3:0] c);
    cmd  = c;
    send = 1'b1;
    cycles(1);
    send = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (pkt_done < target && n < 1000) begin
      cycles(1);
      n++;
    end
    if (pkt_done < target) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    cycles(3);
    rst = 1'b0;
    cycles(50);
    check("idle_busy", int'(busy), 0);
    check("idle_ir", int'(ir_led), 0);

    strobe(4'b0000);
    check("accept_ir", int'(ir_led), 1);
    check("accept_busy", int'(busy), 1);
    wait_done(1, "pkt0");
    check("len_cmd0", last_len, 84);
    check("rises_cmd0", last_rises, 9);
    cycles(5);

    strobe(4'b0101);
    wait_done(2, "pkt5");
    check("len_cmd5", last_len, 100);
    check("rises_cmd5", last_rises, 13);
    cycles(5);

    strobe(4'b1111);
    cycles(1);
    cmd = 4'b0000;
    wait_done(3, "latch");
    check("len_latch", last_len, 116);
    check("rises_latch", last_rises, 17);
    cycles(5);

    strobe(4'b0000);
    cycles(19);
    strobe(4'b1111);
    wait_done(4, "busy_strobe");
    check("len_ignored", last_len, 84);
    check("rises_ignored", last_rises, 9);
    strobe(4'b0000);
    check("b2b_busy", int'(busy), 1);
    check("b2b_ir", int'(ir_led), 1);
    wait_done(5, "b2b");
    check("len_b2b", last_len, 84);
    cycles(5);

    strobe(4'b0000);
    cycles(50);
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("rst_ir", int'(ir_led), 0);
    check("rst_busy", int'(busy), 0);
    wait_done(6, "rst_trunc");
    cycles(3);
    strobe(4'b0101);
    wait_done(7, "post_rst");
    check("len_post_rst", last_len, 100);
    check("rises_post_rst", last_rises, 13);
    cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
